// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// Module  : nibble_serial_adder_pkg
// Brief   : Shared constants for the nibble-serial adder (FSM encoding, slice width).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Nibble index width, never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_add_slice.sv
// ============================================================================
// Module  : nibble_add_slice
// Brief   : Combinational 4-bit ripple-carry adder built from 1-bit full adders.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_add_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = ci;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
            assign s[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
            assign w_c[gi+1] = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co = w_c[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module  : nibble_serial_adder
// Brief   : Multi-cycle WIDTH-bit adder, one nibble per cycle through a single
//           4-bit slice. Define NSA_OVERFLOW_EN to add the signed-overflow port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_cout;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_s4;
    logic                w_c4;
    logic                w_accept;
    logic                w_run;
    logic                w_last;
    logic                w_release;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_run     = (r_state == ST_RUN);
    assign w_last    = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_release = (r_state == ST_DONE) && out_ready;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------ nibble mux
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_add_slice u_slice (
        .x  (w_a_nib),
        .y  (w_b_nib),
        .ci (r_carry),
        .s  (w_s4),
        .co (w_c4)
    );

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
        end else if (w_run) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_s4;
                end
            end
            r_carry <= w_c4;
            // Explicit restart keeps idx in range when NIBBLES is not a power of two.
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_c4;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef NSA_OVERFLOW_EN
    logic r_ovf;

    // Carry into the MSB xor carry out of the MSB, taken on the final nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept || w_release) begin
            r_ovf <= 1'b0;
        end else if (w_run && w_last) begin
            r_ovf <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s4[NIBBLE_W-1] ^ w_c4;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire
